// File: rtl/bubble_multicycle_sequencer_pkg.sv
// Shared encodings for the BUBBLE multi-cycle sequencer: opcodes, functs,
// FSM states, instruction classes and write-back select codes.
package bubble_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_IALU   = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_JUMP   = 3'd3,
        CLS_LOAD   = 3'd4,
        CLS_STORE  = 3'd5
    } class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SUBI  = 6'b011010;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [5:0] ALU_ADD = FN_ADD;
    localparam logic [5:0] ALU_SUB = FN_SUB;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [4:0] LINK_REG = 5'd31;

endpackage

// File: rtl/bubble_multicycle_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer
// (master) and the memory system (slave).
interface bubble_multicycle_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );

endinterface

// File: rtl/bubble_multicycle_sequencer_classify.sv
// Combinational decode of the instruction register into legality, class and
// the datapath controls that stay constant for the instruction's lifetime.
module bubble_instr_classify
    import bubble_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic        legal_o,
    output class_e      cls_o,
    output logic [5:0]  alu_op_o,
    output logic        alu_src_imm_o,
    output logic        imm_zero_ext_o,
    output logic [4:0]  reg_waddr_o,
    output logic [1:0]  wb_sel_o
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = ir_i[31:26];
    assign funct  = ir_i[5:0];

    always_comb begin
        legal_o        = 1'b1;
        cls_o          = CLS_R;
        alu_op_o       = 6'd0;
        alu_src_imm_o  = 1'b0;
        imm_zero_ext_o = 1'b0;
        reg_waddr_o    = 5'd0;
        wb_sel_o       = WB_ALU;
        case (opcode)
            OP_RTYPE: begin
                cls_o       = CLS_R;
                alu_op_o    = funct;
                reg_waddr_o = ir_i[15:11];
                legal_o     = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SUBI, OP_SLTI: begin
                cls_o          = CLS_IALU;
                alu_op_o       = opcode;
                alu_src_imm_o  = 1'b1;
                imm_zero_ext_o = (opcode == OP_ANDI) || (opcode == OP_ORI);
                reg_waddr_o    = ir_i[20:16];
            end
            OP_BEQ, OP_BNE: begin
                cls_o    = CLS_BRANCH;
                alu_op_o = ALU_SUB;
            end
            OP_J: begin
                cls_o = CLS_JUMP;
            end
            OP_JAL: begin
                cls_o       = CLS_JUMP;
                reg_waddr_o = LINK_REG;
                wb_sel_o    = WB_LINK;
            end
            OP_LW: begin
                cls_o         = CLS_LOAD;
                alu_op_o      = ALU_ADD;
                alu_src_imm_o = 1'b1;
                reg_waddr_o   = ir_i[20:16];
                wb_sel_o      = WB_MEM;
            end
            OP_SW: begin
                cls_o         = CLS_STORE;
                alu_op_o      = ALU_ADD;
                alu_src_imm_o = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/bubble_multicycle_sequencer.sv
// Multi-cycle control FSM for the BUBBLE processor: fetch, decode, execute,
// memory and write-back sequencing with PC update and sticky traps.
module bubble_multicycle_sequencer
    import bubble_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    bubble_multicycle_sequencer_if.master        bus,
    input  logic                                 alu_zero,
    output logic [5:0]                           alu_op,
    output logic                                 alu_src_imm,
    output logic                                 imm_zero_ext,
    output logic                                 reg_write,
    output logic [4:0]                           reg_waddr,
    output logic [1:0]                           wb_sel,
    output logic [31:0]                          ir,
    output logic [31:0]                          pc,
    output logic [31:0]                          link_pc,
    output logic [2:0]                           state,
    output logic                                 trap,
    output logic                                 bus_err,
    output logic [31:0]                          instr_retired
);

    localparam logic [31:0] WAIT_LAST = 32'(ACK_TIMEOUT) - 32'd1;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, link_q, retired_q, wait_q;
    logic        imem_req_q, dmem_req_q, dmem_we_q, reg_write_q;
    logic        trap_q, bus_err_q;
    logic        retire, bus_timeout, timeout, taken, active;

    logic        cls_legal, cls_src_imm, cls_zext;
    class_e      cls;
    logic [5:0]  cls_alu_op;
    logic [4:0]  cls_waddr;
    logic [1:0]  cls_wb_sel;
    logic [5:0]  opcode;
    logic [31:0] pc_plus4, br_off;

    bubble_instr_classify u_classify (
        .ir_i           (ir_q),
        .legal_o        (cls_legal),
        .cls_o          (cls),
        .alu_op_o       (cls_alu_op),
        .alu_src_imm_o  (cls_src_imm),
        .imm_zero_ext_o (cls_zext),
        .reg_waddr_o    (cls_waddr),
        .wb_sel_o       (cls_wb_sel)
    );

    assign opcode   = ir_q[31:26];
    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign taken    = ((opcode == OP_BEQ) && alu_zero) || ((opcode == OP_BNE) && !alu_zero);
    assign timeout  = (ACK_TIMEOUT != 0) && (wait_q == WAIT_LAST);

    // Handshakes only count while our own request strobe is up, so the
    // request-free cycle after reset neither accepts an ack nor burns a wait.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        retire      = 1'b0;
        bus_timeout = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_req_q) begin
                    if (bus.imem_ack) begin
                        state_d = ST_DECODE;
                        pc_d    = pc_plus4;
                    end else if (timeout) begin
                        state_d     = ST_TRAP;
                        bus_timeout = 1'b1;
                    end
                end
            end
            ST_DECODE: state_d = cls_legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                case (cls)
                    CLS_BRANCH: begin
                        if (taken) pc_d = pc_q + br_off;
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                    CLS_JUMP: begin
                        pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                        if (opcode == OP_JAL) begin
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_FETCH;
                            retire  = 1'b1;
                        end
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_req_q) begin
                    if (bus.dmem_ack) begin
                        if (cls == CLS_STORE) begin
                            state_d = ST_FETCH;
                            retire  = 1'b1;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (timeout) begin
                        state_d     = ST_TRAP;
                        bus_timeout = 1'b1;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            link_q      <= '0;
            retired_q   <= '0;
            wait_q      <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            reg_write_q <= 1'b0;
            trap_q      <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if ((state_q == ST_FETCH) && imem_req_q && bus.imem_ack) begin
                ir_q   <= bus.imem_rdata;
                link_q <= pc_plus4;
            end
            if (retire) retired_q <= retired_q + 32'd1;
            if (state_d != state_q) wait_q <= '0;
            else if (imem_req_q || dmem_req_q) wait_q <= wait_q + 32'd1;
            imem_req_q  <= (state_d == ST_FETCH);
            dmem_req_q  <= (state_d == ST_MEM);
            dmem_we_q   <= (state_d == ST_MEM) && (cls == CLS_STORE);
            reg_write_q <= (state_d == ST_WB) && (cls_waddr != 5'd0);
            trap_q      <= trap_q | (state_d == ST_TRAP);
            bus_err_q   <= bus_err_q | bus_timeout;
        end
    end

    assign active = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                    (state_q == ST_MEM) || (state_q == ST_WB);

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;

    assign alu_op        = active ? cls_alu_op : 6'd0;
    assign alu_src_imm   = active && cls_src_imm;
    assign imm_zero_ext  = active && cls_zext;
    assign reg_write     = reg_write_q;
    assign reg_waddr     = cls_waddr;
    assign wb_sel        = cls_wb_sel;
    assign ir            = ir_q;
    assign pc            = pc_q;
    assign link_pc       = link_q;
    assign state         = state_q;
    assign trap          = trap_q;
    assign bus_err       = bus_err_q;
    assign instr_retired = retired_q;

endmodule

// File: doc/bubble_multicycle_sequencer.md
Name: bubble_multicycle_sequencer

Overview:
Multi-cycle control FSM for the CSE BUBBLE processor. It fetches each instruction over a req/ack instruction-memory port, holds it in an instruction register, and classifies opcode/funct. It then steps the shared ALU/register-file datapath through EXEC, MEM and WB. It owns PC update (sequential, branch, jump), the data-memory handshake and the traps for illegal opcodes and bus timeouts.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ACK_TIMEOUT, 255, maximum cycles to wait for imem_ack/dmem_ack before trapping; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address, equals pc
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
dmem_req  out  1  data access request
dmem_we  out  1  1 = store (sw), 0 = load (lw)
dmem_ack  in  1  data access complete
alu_zero  in  1  datapath ALU zero flag, valid in EXEC
alu_op  out  6  ALU operation code
alu_src_imm  out  1  ALU B operand = immediate
imm_zero_ext  out  1  immediate zero-extended (andi/ori), else sign-extended
reg_write  out  1  register-file write strobe, one cycle in WB
reg_waddr  out  5  destination register
wb_sel  out  2  0 = ALU, 1 = memory, 2 = link
ir  out  32  instruction register
pc  out  32  program counter
link_pc  out  32  return address for jal
state  out  3  current FSM state, for debug
trap  out  1  sticky; illegal opcode or bus timeout
bus_err  out  1  sticky; trap cause was a timeout
instr_retired  out  32  count of completed instructions

Behaviour:
- Reset, applied on the clock edge while rst=1, from any state including mid-handshake:
  - state=FETCH, pc=RESET_PC, ir=0, link_pc=0, instr_retired=0.
  - trap=0, bus_err=0, timeout counter=0.
  - All strobes (imem_req, dmem_req, dmem_we, reg_write) are 0 in the cycle after reset.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: ir<=imem_rdata, pc<=pc+4 (32-bit wrap), link_pc<=pc+4, go to DECODE.
  - If ack is not received within ACK_TIMEOUT cycles: go to TRAP with bus_err=1.
- DECODE: one cycle.
  - Legal opcodes: 000000 (funct 100000 / 100010 / 100100 / 100101 / 101010), 001000 addi, 001100 andi, 001101 ori, 011010 subi, 001010 slti, 000100 beq, 000101 bne, 000010 j, 000011 jal, 100011 lw, 101011 sw.
  - Any other opcode, or an R-type with any other funct: go to TRAP. Otherwise go to EXEC.
- alu_op, alu_src_imm and imm_zero_ext are driven from ir, held stable in DECODE through WB, and 0 in FETCH and TRAP.
  - R-type: alu_op = funct.
  - I-type ALU instructions: alu_op = opcode.
  - beq/bne: alu_op = 100010 (subtract).
  - lw/sw: alu_op = 100000 (add).
  - j/jal: alu_op = 000000.
- EXEC: one cycle.
  - beq taken when alu_zero=1; bne taken when alu_zero=0. If taken: pc <= pc + (sext(ir[15:0])<<2). Then go to FETCH.
  - j/jal: pc <= {pc[31:28], ir[25:0], 2'b00}. j then goes to FETCH, jal to WB.
  - R-type and I-type ALU instructions go to WB; lw/sw go to MEM.
- MEM:
  - dmem_req=1, dmem_we = (opcode==sw).
  - On dmem_ack: lw goes to WB; sw goes to FETCH and retires.
  - Same timeout rule as FETCH.
- WB: reg_write=1 for exactly one cycle, then go to FETCH and retire.
  - reg_waddr: ir[15:11] for R-type, ir[20:16] for I-type and lw, 31 for jal.
  - wb_sel: ALU, memory (lw) or link (jal).
  - reg_write is suppressed when reg_waddr=0.
- Retire: instr_retired increments by 1 (wraps) on each transition into FETCH from EXEC, MEM or WB.
- TRAP: absorbing until rst. All strobes 0, trap=1.
- Timeout counter: resets on every state entry; an ack arriving on the final permitted cycle is accepted.
- Ack seen outside its own state (imem_ack outside FETCH, dmem_ack outside MEM) is ignored.

Decomposition:
- Package bubble_pkg holds:
  - opcode and funct constants;
  - state encoding;
  - wb_sel codes;
  - ALU op codes for subtract and add.
- One natural sub-module: bubble_instr_classify. It is combinational, takes ir, and returns legal, class (R / I-ALU / branch / jump / load / store), alu_op, alu_src_imm, imm_zero_ext, reg_waddr and wb_sel.

Test Plan:
1. add $3,$1,$2 (0x00221820), imem_ack delayed 3 cycles -> imem_req held 4 cycles, pc=0x4; WB shows reg_write=1, reg_waddr=3, wb_sel=0, alu_op=100000; instr_retired=1.
2. beq (0x10000003) at pc=0x10 with alu_zero=1 -> pc=0x20 and no reg_write. Repeat with alu_zero=0 -> pc=0x14.
3. jal 0x0C000040 at pc=0x100 -> pc=0x100, link_pc=0x104, reg_waddr=31, wb_sel=2, single reg_write pulse.
4. lw $5,8($2) (0x8C450008), dmem_ack after 2 cycles -> dmem_req=1 and dmem_we=0 for 3 cycles, then WB with reg_waddr=5, wb_sel=1. sw (0xAC450008) -> dmem_we=1, no WB, instr_retired increments.
5. Fetch 0xFC000000 (illegal) -> TRAP, trap=1, bus_err=0, no further imem_req. Assert rst -> state=FETCH, pc=RESET_PC, trap=0.
6. ACK_TIMEOUT=4 with imem_ack held 0 -> TRAP exactly after the 4th wait cycle, with bus_err=1. Separately, assert rst mid-MEM -> dmem_req=0 on the next cycle.
